// File: rtl/sync_fifo_pkg.sv
// ----------------------------------------------------------------------------
// sync_fifo_pkg
// Shared definitions for the synchronous FIFO controller.
//   PTR_W(aw)    : pointer width for an aw-bit RAM address (address + wrap bit)
//   AFULL_MARGIN : default distance of the almost-full threshold below depth
//   ptr_t        : pointer type at the default address width
// ----------------------------------------------------------------------------
package sync_fifo_pkg;

    localparam int unsigned AW_DEFAULT   = 8;
    localparam int unsigned AFULL_MARGIN = 4;

    // One extra MSB distinguishes full from empty when the address bits match.
    function automatic int unsigned PTR_W(input int unsigned aw);
        return aw + 1;
    endfunction

    typedef logic [AW_DEFAULT:0] ptr_t;

endpackage

// File: rtl/sync_fifo_ctrl_ptr.sv
// ----------------------------------------------------------------------------
// fifo_ptr
// One FIFO pointer (RAM address plus wrap bit), incrementing modulo
// 2^(AW+1), with synchronous clear. Used once for writes, once for reads.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear to zero (wins over inc)
//   inc        : advance by one at the next edge
//   ptr        : current pointer value
//   ptr_nxt    : value the pointer takes at the next edge
// ----------------------------------------------------------------------------
module fifo_ptr
    import sync_fifo_pkg::*;
#(
    parameter int unsigned AW = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               inc,
    output logic [PTR_W(AW)-1:0] ptr,
    output logic [PTR_W(AW)-1:0] ptr_nxt
);

    localparam int unsigned PW = PTR_W(AW);

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (clr) begin
            ptr_d = '0;
        end else if (inc) begin
            ptr_d = ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr     = ptr_q;
    assign ptr_nxt = ptr_d;

endmodule

// File: rtl/sync_fifo_ctrl.sv
// ----------------------------------------------------------------------------
// sync_fifo_ctrl
// Controller for a FIFO built on an external dual-port RAM with combinational
// read. Accepts a valid/ready stream upstream, writes it into the RAM, and
// presents a first-word-fall-through valid/ready stream downstream.
//
// Optional feature: define SYNC_FIFO_CTRL_LEVEL_EN to add the registered
// level counter and almost_full flag (and the AFULL_TH parameter).
//
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   flush                 : synchronous clear of all contents
//   in_valid/ready/data   : upstream stream
//   out_valid/ready/data  : downstream stream (head word)
//   mem_wr_en/addr/data   : RAM write port
//   mem_rd_en/addr/data   : RAM read port (read data is combinational)
//   full, empty           : registered occupancy flags
//   level, almost_full    : registered count and threshold flag (macro only)
// ----------------------------------------------------------------------------
module sync_fifo_ctrl
    import sync_fifo_pkg::*;
#(
    parameter int unsigned AW = 8,
    parameter int unsigned DW = 8
`ifdef SYNC_FIFO_CTRL_LEVEL_EN
    ,
    parameter int unsigned AFULL_TH = (1 << AW) - AFULL_MARGIN
`endif
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          mem_wr_en,
    output logic [AW-1:0] mem_wr_addr,
    output logic [DW-1:0] mem_wr_data,
    output logic          mem_rd_en,
    output logic [AW-1:0] mem_rd_addr,
    input  logic [DW-1:0] mem_rd_data,
    output logic          full,
    output logic          empty
`ifdef SYNC_FIFO_CTRL_LEVEL_EN
    ,
    output logic [AW:0]   level,
    output logic          almost_full
`endif
);

    localparam int unsigned PW = PTR_W(AW);

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] wr_ptr_nxt;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] rd_ptr_nxt;

    logic init_q;
    logic full_q;
    logic full_d;
    logic empty_q;
    logic empty_d;
    logic push;
    logic pop;

    // Handshakes look only at registered flags, init_q and flush, so a pop
    // never frees a slot for a push in the same cycle and vice versa.
    always_comb begin
        in_ready    = init_q & ~full_q & ~flush;
        push        = in_valid & in_ready;
        out_valid   = ~empty_q & ~flush;
        pop         = out_valid & out_ready;

        mem_wr_en   = push;
        mem_wr_addr = wr_ptr[AW-1:0];
        mem_wr_data = in_data;
        mem_rd_en   = ~empty_q;
        mem_rd_addr = rd_ptr[AW-1:0];
        out_data    = mem_rd_data;
    end

    fifo_ptr #(
        .AW (AW)
    ) u_wr_ptr (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (flush),
        .inc     (push),
        .ptr     (wr_ptr),
        .ptr_nxt (wr_ptr_nxt)
    );

    fifo_ptr #(
        .AW (AW)
    ) u_rd_ptr (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (flush),
        .inc     (pop),
        .ptr     (rd_ptr),
        .ptr_nxt (rd_ptr_nxt)
    );

    // Flags come from next-cycle pointers so they are plain registers.
    // A flush zeroes both next pointers, which yields empty=1, full=0.
    always_comb begin
        empty_d = (wr_ptr_nxt == rd_ptr_nxt);
        full_d  = (wr_ptr_nxt[AW] != rd_ptr_nxt[AW]) &&
                  (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_q  <= 1'b0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
        end else begin
            init_q  <= 1'b1;
            empty_q <= empty_d;
            full_q  <= full_d;
        end
    end

    assign full  = full_q;
    assign empty = empty_q;

`ifdef SYNC_FIFO_CTRL_LEVEL_EN
    logic [AW:0] level_q;
    logic [AW:0] level_d;
    logic        afull_q;
    logic        afull_d;

    always_comb begin
        level_d = level_q;
        if (flush) begin
            level_d = '0;
        end else if (push && !pop) begin
            level_d = level_q + PW'(1);
        end else if (pop && !push) begin
            level_d = level_q - PW'(1);
        end
        afull_d = (32'(level_d) >= AFULL_TH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= '0;
            afull_q <= 1'b0;
        end else begin
            level_q <= level_d;
            afull_q <= afull_d;
        end
    end

    assign level       = level_q;
    assign almost_full = afull_q;
`endif

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// ----------------------------------------------------------------------------
// tb_sync_fifo_ctrl
// Directed and randomized stimulus for sync_fifo_ctrl with AW=2 (depth 4),
// checked every cycle against a queue-based model of the FIFO contents.
// ----------------------------------------------------------------------------
module tb_sync_fifo_ctrl;

    localparam int unsigned AW    = 2;
    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 1 << AW;
    localparam int unsigned AF_TH = 3;

    logic          clk;
    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          mem_wr_en;
    logic [AW-1:0] mem_wr_addr;
    logic [DW-1:0] mem_wr_data;
    logic          mem_rd_en;
    logic [AW-1:0] mem_rd_addr;
    logic [DW-1:0] mem_rd_data;
    logic          full;
    logic          empty;
`ifdef SYNC_FIFO_CTRL_LEVEL_EN
    logic [AW:0]   level;
    logic          almost_full;
`endif

    sync_fifo_ctrl #(
        .AW       (AW),
        .DW       (DW)
`ifdef SYNC_FIFO_CTRL_LEVEL_EN
        ,
        .AFULL_TH (AF_TH)
`endif
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_addr (mem_wr_addr),
        .mem_wr_data (mem_wr_data),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data),
        .full        (full),
        .empty       (empty)
`ifdef SYNC_FIFO_CTRL_LEVEL_EN
        ,
        .level       (level),
        .almost_full (almost_full)
`endif
    );

    // RAM model: synchronous write, combinational read.
    logic [DW-1:0] ram [DEPTH];
    always_ff @(posedge clk) begin
        if (mem_wr_en) ram[mem_wr_addr] <= mem_wr_data;
    end
    assign mem_rd_data = ram[mem_rd_addr];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: contents as a queue, plus running push/pop counts
    // whose residues give the RAM addresses.
    logic [DW-1:0] q[$];
    int unsigned   wr_cnt;
    int unsigned   rd_cnt;
    bit            inited;
    int            checks;
    int            failures;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        wr_cnt = 0;
        rd_cnt = 0;
        inited = 1'b0;
    endtask

    function automatic bit exp_in_ready();
        return inited && (q.size() < DEPTH) && !flush;
    endfunction

    function automatic bit exp_out_valid();
        return (q.size() != 0) && !flush;
    endfunction

    task automatic check_all();
        bit ir;
        ir = exp_in_ready();
        chk("in_ready",    32'(in_ready),    32'(ir));
        chk("out_valid",   32'(out_valid),   32'(exp_out_valid()));
        chk("empty",       32'(empty),       32'(q.size() == 0));
        chk("full",        32'(full),        32'(q.size() == DEPTH));
        chk("mem_wr_en",   32'(mem_wr_en),   32'(in_valid && ir));
        chk("mem_wr_addr", 32'(mem_wr_addr), wr_cnt % DEPTH);
        chk("mem_rd_en",   32'(mem_rd_en),   32'(q.size() != 0));
        chk("mem_rd_addr", 32'(mem_rd_addr), rd_cnt % DEPTH);
        if (in_valid) chk("mem_wr_data", 32'(mem_wr_data), 32'(in_data));
        if (q.size() != 0) chk("out_data", 32'(out_data), 32'(q[0]));
`ifdef SYNC_FIFO_CTRL_LEVEL_EN
        chk("level",       32'(level),       q.size());
        chk("almost_full", 32'(almost_full), 32'(q.size() >= AF_TH));
`endif
    endtask

    // One clock cycle: drive, check just before the edge, then advance model.
    task automatic cyc(input logic iv, input logic [DW-1:0] id, input logic ordy,
                       input logic fl);
        bit do_push;
        bit do_pop;
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        flush     = fl;
        #4;
        check_all();
        do_push = iv && exp_in_ready();
        do_pop  = ordy && exp_out_valid();
        @(posedge clk);
        #1;
        if (!rst_n) begin
            model_reset();
        end else begin
            if (fl) begin
                q.delete();
                wr_cnt = 0;
                rd_cnt = 0;
            end else begin
                if (do_pop) begin
                    void'(q.pop_front());
                    rd_cnt++;
                end
                if (do_push) begin
                    q.push_back(id);
                    wr_cnt++;
                end
            end
            inited = 1'b1;
        end
    endtask

    logic [DW-1:0] fill_words [4];

    initial begin
        checks   = 0;
        failures = 0;
        fill_words[0] = 8'hA1;
        fill_words[1] = 8'hB2;
        fill_words[2] = 8'hC3;
        fill_words[3] = 8'hD4;
        model_reset();
        rst_n     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h11;
        out_ready = 1'b0;
        #1 rst_n  = 1'b0;

        // Reset held with in_valid=1: nothing accepted.
        cyc(1'b1, 8'h11, 1'b0, 1'b0);
        cyc(1'b1, 8'h12, 1'b1, 1'b0);
        rst_n = 1'b1;
        // First edge after release only sets init; in_ready is still 0 here.
        cyc(1'b1, 8'h13, 1'b0, 1'b0);
        chk("in_ready_after_init", 32'(in_ready), 32'(1'b1));
        // Bring back to empty before the fill test.
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);

        // Fill, overflow attempt, drain; twice so the addresses wrap.
        repeat (2) begin
            for (int i = 0; i < 4; i++) cyc(1'b1, fill_words[i], 1'b0, 1'b0);
            cyc(1'b1, 8'hE5, 1'b0, 1'b0);
            for (int i = 0; i < 4; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
        end

        // Concurrent push and pop with two entries held.
        cyc(1'b1, 8'h21, 1'b0, 1'b0);
        cyc(1'b1, 8'h22, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) cyc(1'b1, 8'h30 + 8'(i), 1'b1, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);

        // Flush with three entries held and a word offered in the same cycle.
        cyc(1'b1, 8'h41, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        cyc(1'b1, 8'h55, 1'b1, 1'b1);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);

        // Almost-full threshold crossing: three pushes, one pop.
        for (int i = 0; i < 3; i++) cyc(1'b1, 8'h60 + 8'(i), 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);

        // Randomized traffic with occasional flushes; bias alternates between
        // filling and draining so both boundaries are visited.
        for (int i = 0; i < 400; i++) begin
            bit fill_bias;
            fill_bias = ((i / 40) % 2) == 0;
            cyc(($urandom_range(0, 3) != 0) == fill_bias || $urandom_range(0, 1) == 1 ?
                    1'($urandom_range(0, 1) | 32'(fill_bias)) : 1'b0,
                8'($urandom),
                1'($urandom_range(0, 1) | 32'(!fill_bias)),
                1'($urandom_range(0, 47) == 0));
        end

        // Asynchronous reset in the middle of a cycle with data held.
        for (int i = 0; i < 3; i++) cyc(1'b1, 8'h70 + 8'(i), 1'b0, 1'b0);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        cyc(1'b1, 8'h80, 1'b1, 1'b0);
        rst_n = 1'b1;
        cyc(1'b1, 8'h81, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sync_fifo_ctrl.md
# sync_fifo_ctrl

Synchronous FIFO controller that sits on both ports of the team's dual-port SRAM model. It drives the RAM write port from an upstream valid/ready stream and drives the RAM read port to present a first-word-fall-through valid/ready stream downstream. Storage stays external. This block owns the pointers, flags, the flush path and the handshakes.

## Interface
- AW, 8, address width; RAM depth is 2^AW
- DW, 8, data width
- AFULL_TH, (1<<AW)-4, almost-full threshold in entries; used only with the level feature
- clk  in  1  clock; all flops on posedge
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous clear of all contents
- in_valid  in  1  upstream word present
- in_ready  out  1  controller accepts the word this cycle
- in_data  in  DW  upstream word
- out_valid  out  1  head word present
- out_ready  in  1  downstream accepts the head word
- out_data  out  DW  head word
- mem_wr_en  out  1  RAM write enable
- mem_wr_addr  out  AW  RAM write address
- mem_wr_data  out  DW  RAM write data
- mem_rd_en  out  1  RAM read enable
- mem_rd_addr  out  AW  RAM read address
- mem_rd_data  in  DW  RAM combinational read data
- full  out  1  DEPTH entries held
- empty  out  1  zero entries held
- level  out  AW+1  entry count; present only with the macro
- almost_full  out  1  level >= AFULL_TH; present only with the macro

## Operation
- Pointers wr_ptr and rd_ptr are AW+1 bits: the low AW bits are the RAM address, the MSB is the wrap bit. Both increment modulo 2^(AW+1).
- full_q and empty_q are registers computed from next-cycle pointers:
  - empty when the pointers are equal
  - full when the MSBs differ and the low bits are equal
- init_q resets to 0 and sets to 1 on the first clk edge after rst_n deasserts.
- in_ready = init_q & !full_q & !flush.
- push = in_valid & in_ready.
  - mem_wr_en = push
  - mem_wr_addr = wr_ptr[AW-1:0]
  - mem_wr_data = in_data
- out_valid = !empty_q & !flush.
- mem_rd_en = !empty_q. mem_rd_addr = rd_ptr[AW-1:0]. out_data = mem_rd_data.
- pop = out_valid & out_ready.
- push and pop in the same cycle: both pointers advance; level and flags are unchanged.
- No bypass:
  - When full, in_ready is 0 even if a pop occurs that cycle.
  - When empty, out_valid is 0 even if a push occurs that cycle.
- flush wins over push and pop. The next edge zeroes both pointers and sets empty_q=1, full_q=0. A word offered in the flush cycle is discarded.
- Reset values: in_ready=0, out_valid=0, empty=1, full=0, mem_wr_en=0, mem_rd_en=0, all addresses 0, level=0, almost_full=0.
- Reset asserted mid-operation discards all contents immediately (asynchronous).
- Handshake rules: in_data must be held while in_valid & !in_ready. out_data stays stable while out_valid & !out_ready.

## Timing
- Push-to-visible latency: a word pushed at edge N gives out_valid=1 in the cycle after edge N, with out_data equal to that word.
- Pop: rd_ptr advances at the accepting edge. The next word appears in the following cycle with zero bubbles.
- Sustained throughput: one push and one pop per cycle.
- full/empty/level/almost_full are registered and change only on clk edges.
- in_ready, out_valid and mem_* depend combinationally on the flags, init_q, flush and in_valid only. There is no path from out_ready to in_ready.

## Configuration
- Macro SYNC_FIFO_CTRL_LEVEL_EN.
- Defined:
  - level is an AW+1-bit registered counter: +1 on push only, -1 on pop only, cleared by flush and reset.
  - almost_full = (level >= AFULL_TH), registered.
- Undefined: the level and almost_full ports and the counter are absent. All other behaviour is identical.

## Structure
- A shared package sync_fifo_pkg holds:
  - the pointer width helper PTR_W(AW) = AW+1
  - the default AFULL margin constant (4)
  - the ptr_t typedef for parameterised pointers
- One natural sub-module, fifo_ptr. It holds one AW+1-bit pointer with increment and synchronous clear, and is instantiated twice (write and read).
- Flag and level logic stays in the top.

## Test plan
Test plan uses AW=2 (DEPTH=4).
- Reset: hold rst_n=0 with in_valid=1 -> in_ready=0, mem_wr_en=0, out_valid=0, empty=1, full=0. Release rst_n -> in_ready=1 after the first edge.
- Fill: push 0xA1, 0xB2, 0xC3, 0xD4 back-to-back with out_ready=0 -> full=1 after the 4th edge, in_ready=0. A 5th word 0xE5 gives mem_wr_en=0 and is lost.
- Drain: then out_ready=1 -> out_data is 0xA1, 0xB2, 0xC3, 0xD4 in consecutive cycles. empty=1 after the 4th pop edge. Repeat the fill from wr_ptr=4 -> mem_wr_addr wraps 3 -> 0.
- Concurrent: with 2 entries held, push and pop every cycle for 8 cycles -> count/flags unchanged and order preserved. With the macro, level stays 2.
- Flush: with 3 entries held, assert flush with in_valid=1, in_data=0x55, out_ready=1 -> no push and no pop that cycle. Next cycle empty=1, out_valid=0, and 0x55 never appears.
- Macro with AFULL_TH=3: push 3 words -> almost_full rises after the 3rd push edge. One pop -> almost_full falls after that edge.
